ibex_bus_arbiter: RTL



---
 rtl/ibex_bus_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ibex_bus_arbiter.sv
// 2:1 round-robin arbiter sharing one Ibex req/gnt/rvalid port between data (0) and instruction (1) requesters.
// Optional grant/stall counters are enabled with the IBEX_BUS_ARB_PERF_EN macro.
module ibex_bus_arbiter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req,
  output logic                   m0_gnt,
  output logic                   m0_rvalid,
  input  logic [AddrWidth-1:0]   m0_addr,
  input  logic                   m0_we,
  input  logic [DataWidth/8-1:0] m0_be,
  input  logic [DataWidth-1:0]   m0_wdata,
  output logic [DataWidth-1:0]   m0_rdata,
  output logic                   m0_err,
  input  logic                   m1_req,
  output logic                   m1_gnt,
  output logic                   m1_rvalid,
  input  logic [AddrWidth-1:0]   m1_addr,
  input  logic                   m1_we,
  input  logic [DataWidth/8-1:0] m1_be,
  input  logic [DataWidth-1:0]   m1_wdata,
  output logic [DataWidth-1:0]   m1_rdata,
  output logic                   m1_err,
  output logic                   s_req,
  input  logic                   s_gnt,
  input  logic                   s_rvalid,
  output logic [AddrWidth-1:0]   s_addr,
  output logic                   s_we,
  output logic [DataWidth/8-1:0] s_be,
  output logic [DataWidth-1:0]   s_wdata,
  input  logic [DataWidth-1:0]   s_rdata,
  input  logic                   s_err,
  output logic                   unexp_rvalid
`ifdef IBEX_BUS_ARB_PERF_EN
  ,
  output logic [31:0]            perf_gnt0,
  output logic [31:0]            perf_gnt1,
  output logic [31:0]            perf_stall
`endif
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  logic                      rr_ptr;
  logic                      lock;
  logic                      lock_id;
  logic                      sel;
  logic                      sel_req;
  logic                      grant;
  logic                      pop;
  logic                      head;
  logic [MaxOutstanding-1:0] owner_q;
  logic [PtrW-1:0]           wr_ptr;
  logic [PtrW-1:0]           rd_ptr;
  logic [CntW-1:0]           count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // A locked request keeps its owner; otherwise a lone requester wins and ties go to rr_ptr.
  always_comb begin
    sel = rr_ptr;
    if (lock) begin
      sel = lock_id;
    end else if (m0_req && !m1_req) begin
      sel = 1'b0;
    end else if (m1_req && !m0_req) begin
      sel = 1'b1;
    end
  end

  assign sel_req = sel ? m1_req : m0_req;
  assign s_req   = !rst && sel_req && (lock || (count < MaxCnt));
  assign s_addr  = sel ? m1_addr  : m0_addr;
  assign s_we    = sel ? m1_we    : m0_we;
  assign s_be    = sel ? m1_be    : m0_be;
  assign s_wdata = sel ? m1_wdata : m0_wdata;

  assign grant  = s_req && s_gnt;
  assign m0_gnt = grant && !sel;
  assign m1_gnt = grant && sel;

  assign head         = owner_q[rd_ptr];
  assign pop          = !rst && s_rvalid && (count != '0);
  assign m0_rvalid    = pop && !head;
  assign m1_rvalid    = pop && head;
  assign m0_rdata     = s_rdata;
  assign m1_rdata     = s_rdata;
  assign m0_err       = s_err;
  assign m1_err       = s_err;
  assign unexp_rvalid = !rst && s_rvalid && (count == '0);

  // Owner FIFO records who was granted so responses route back in grant order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= 1'b0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      owner_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (grant) begin
        owner_q[wr_ptr] <= sel;
        wr_ptr          <= ptr_inc(wr_ptr);
        rr_ptr          <= ~sel;
        lock            <= 1'b0;
      end else if (s_req) begin
        lock    <= 1'b1;
        lock_id <= sel;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (grant && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !grant) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef IBEX_BUS_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_gnt0  <= '0;
      perf_gnt1  <= '0;
      perf_stall <= '0;
    end else begin
      if (m0_gnt && (perf_gnt0 != 32'hFFFF_FFFF)) begin
        perf_gnt0 <= perf_gnt0 + 32'd1;
      end
      if (m1_gnt && (perf_gnt1 != 32'hFFFF_FFFF)) begin
        perf_gnt1 <= perf_gnt1 + 32'd1;
      end
      if ((m0_req || m1_req) && !grant && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
